// File: rtl/spi_pwm_config.sv
// SPI mode-0 target that loads the five PWM control registers from 16-bit frames.
// Optional read-back on cipo_out is enabled by defining SPI_READBACK_EN.
module spi_pwm_config #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update,
  output logic       frame_err
`ifdef SPI_READBACK_EN
  ,
  output logic       cipo_out
`endif
);

  localparam int REG_COUNT    = 5;
  localparam int ADDR_LIM_I   = (NUM_REGS < REG_COUNT) ? NUM_REGS : REG_COUNT;
  localparam logic [6:0] ADDR_LIMIT = 7'(ADDR_LIM_I);
  localparam int FLUSH_CYCLES = SYNC_STAGES + 2;
  localparam int FLUSH_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_prev_q, sclk_prev_d;
  logic copi_prev_q, copi_prev_d;
  logic ncs_prev_q, ncs_prev_d;
  logic sclk_rise_q, sclk_rise_d;
  logic ncs_rise_q, ncs_rise_d;
  logic ncs_fall_q, ncs_fall_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic armed_q, armed_d;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  regs_q [REG_COUNT];
  logic [7:0]  regs_d [REG_COUNT];
  logic        cfg_update_q, cfg_update_d;
  logic        frame_err_q, frame_err_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

  // Pin synchronizers, delayed copies and registered edge pulses.
  // The delayed copi/ncs levels line up with the registered pulses.
  // Arming waits for the pipeline to refill after reset and then for ncs high,
  // so a frame already in progress at reset release is never accepted.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi_in};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
    sclk_prev_d = sclk_s;
    copi_prev_d = copi_s;
    ncs_prev_d  = ncs_s;
    sclk_rise_d = sclk_s & ~sclk_prev_q;
    ncs_rise_d  = ncs_s & ~ncs_prev_q;
    ncs_fall_d  = ~ncs_s & ncs_prev_q;
    if (flush_q != FLUSH_DONE) begin
      flush_d = flush_q + FLUSH_W'(1);
      armed_d = 1'b0;
    end else begin
      flush_d = flush_q;
      armed_d = armed_q | ncs_s;
    end
  end

  // Frame FSM: shift bits in, validate length, commit the write atomically.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    regs_d       = regs_q;
    cfg_update_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall_q && armed_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 5'd0;
          shift_d   = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise_q) begin
          if (bit_cnt_q == 5'd16) begin
            state_d = ST_COMMIT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (sclk_rise_q && !ncs_prev_q) begin
          shift_d   = {shift_q[14:0], copi_prev_q};
          bit_cnt_d = (bit_cnt_q == 5'd17) ? 5'd17 : bit_cnt_q + 5'd1;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        if (shift_q[15] && (shift_q[14:8] < ADDR_LIMIT)) begin
          for (int i = 0; i < REG_COUNT; i++) begin
            if (shift_q[14:8] == 7'(i)) begin
              regs_d[i] = shift_q[7:0];
            end else begin
              regs_d[i] = regs_q[i];
            end
          end
          cfg_update_d = 1'b1;
        end else begin
          cfg_update_d = 1'b0;
        end
        // A new frame may already be starting; take its falling edge here.
        if (ncs_fall_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 5'd0;
          shift_d   = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SPI_READBACK_EN
  logic sclk_fall_q, sclk_fall_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rd_sel_s;
  logic cipo_q, cipo_d;

  // Read-back: load the addressed register after the header byte, then shift on sclk falls.
  always_comb begin
    sclk_fall_d = ~sclk_s & sclk_prev_q;
    rd_sel_s    = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if ((shift_d[6:0] < ADDR_LIMIT) && (shift_d[6:0] == 7'(i))) begin
        rd_sel_s = regs_q[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
    if (state_d != ST_SHIFT) begin
      tx_d = 8'h00;
    end else if ((state_q == ST_SHIFT) && (bit_cnt_q == 5'd7) && (bit_cnt_d == 5'd8) && !shift_d[7]) begin
      tx_d = rd_sel_s;
    end else if ((state_q == ST_SHIFT) && sclk_fall_q && (bit_cnt_q >= 5'd9) && (bit_cnt_q <= 5'd15)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end else begin
      tx_d = tx_q;
    end
    cipo_d = (state_d == ST_SHIFT) ? tx_d[7] : 1'b0;
  end

  // Read-back registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_fall_q <= 1'b0;
      tx_q        <= 8'h00;
      cipo_q      <= 1'b0;
    end else begin
      sclk_fall_q <= sclk_fall_d;
      tx_q        <= tx_d;
      cipo_q      <= cipo_d;
    end
  end

  assign cipo_out = cipo_q;
`endif

  // State registers; synchronizers reset to the idle pin levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q  <= {SYNC_STAGES{1'b0}};
      copi_sync_q  <= {SYNC_STAGES{1'b0}};
      ncs_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_prev_q  <= 1'b0;
      copi_prev_q  <= 1'b0;
      ncs_prev_q   <= 1'b1;
      sclk_rise_q  <= 1'b0;
      ncs_rise_q   <= 1'b0;
      ncs_fall_q   <= 1'b0;
      flush_q      <= {FLUSH_W{1'b0}};
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 5'd0;
      shift_q      <= 16'h0000;
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= 8'h00;
      end
      cfg_update_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      copi_sync_q  <= copi_sync_d;
      ncs_sync_q   <= ncs_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      copi_prev_q  <= copi_prev_d;
      ncs_prev_q   <= ncs_prev_d;
      sclk_rise_q  <= sclk_rise_d;
      ncs_rise_q   <= ncs_rise_d;
      ncs_fall_q   <= ncs_fall_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      regs_q       <= regs_d;
      cfg_update_q <= cfg_update_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign cfg_update      = cfg_update_q;
  assign frame_err       = frame_err_q;

endmodule

// File: doc/spi_pwm_config.md
Name: spi_pwm_config

Overview:
- SPI-mode-0 target that configures the PWM peripheral's five control registers. Inputs are serial pins, oversampled in the system clock domain.
- Decodes 16-bit frames: bit15 = R/W, bits14:8 = address, bits7:0 = data.
- Commits a write atomically at frame end and drives the register outputs straight into the pwm_peripheral enable and duty ports.
- Sits between the uio/ui input pins and pwm_peripheral in the top level.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchronizer (minimum 2)
NUM_REGS, 5, number of implemented addresses; addresses >= NUM_REGS are ignored

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sclk_in  input  1  SPI clock from pin, asynchronous
copi_in  input  1  SPI data in from pin, asynchronous
ncs_in  input  1  SPI chip select, active low, asynchronous
en_reg_out_7_0  output  8  address 0x00
en_reg_out_15_8  output  8  address 0x01
en_reg_pwm_7_0  output  8  address 0x02
en_reg_pwm_15_8  output  8  address 0x03
pwm_duty_cycle  output  8  address 0x04
cfg_update  output  1  one-cycle pulse when a register is written
frame_err  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Synchronizers: sclk_in, copi_in and ncs_in each pass through SYNC_STAGES flops.
- Edge detection: one further registered copy of sync sclk and sync ncs. sclk_rise = prev 0 and cur 1. ncs_fall and ncs_rise are defined the same way.
- Clock ratio: clk must be at least 4x sclk. Behaviour below that ratio is undefined.
- Reset: all five registers = 0x00, cfg_update = 0, frame_err = 0, FSM = IDLE, bit counter = 0, shift register = 0. Synchronizer flops reset to idle pin levels: sclk 0, copi 0, ncs 1.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE: on ncs_fall go to SHIFT, clear the 5-bit bit counter and the 16-bit shift register. All other events are ignored.
- SHIFT, sclk_rise with ncs low: shift_reg <= {shift_reg[14:0], copi_sync}; the frame is MSB first. Counter increments and saturates at 17.
- SHIFT, ncs_rise: if counter == 16, go to COMMIT. Otherwise (short frame, or more than 16 edges) pulse frame_err for 1 cycle and go to IDLE; no register changes.
- SHIFT, ncs_rise and sclk_rise in the same cycle: ncs_rise wins and the sclk edge is dropped.
- COMMIT, exactly 1 cycle:
  - if shift_reg[15] == 1 and address < NUM_REGS: the addressed register <= shift_reg[7:0], and cfg_update = 1 in the following cycle;
  - read frames (bit15 = 0) and out-of-range addresses: no write, no cfg_update, no frame_err.
  - Then go to IDLE.
- Latency: new register value is visible SYNC_STAGES+3 clk cycles after ncs_in rises at the pin.
- Outputs are registered and glitch-free; unaddressed registers hold their values.
- Reset mid-frame: the partial frame is discarded. After rst deasserts with ncs already low, no frame is accepted until ncs goes high and then low again.
- Back-to-back frames: an ncs_fall arriving while in COMMIT is not lost. COMMIT lasts 1 cycle, and the edge detector sees ncs_fall at least 2 cycles after ncs_rise under the 4x ratio.

Optional Feature:
- Macro SPI_READBACK_EN.
- Defined:
  - adds output port cipo_out (1 bit, reset 0);
  - in a read frame, when the counter reaches 8, an 8-bit tx register loads the addressed register value (0x00 if address >= NUM_REGS);
  - cipo_out presents tx[7] and shifts left on each sync sclk falling edge, for bits 8..15;
  - cipo_out returns to 0 in IDLE.
- Undefined: no cipo_out port, and read frames are silently ignored.

Test Plan:
- Reset, then frame 0x8455 (write addr 0x04, data 0x55) -> pwm_duty_cycle = 0x55 exactly SYNC_STAGES+3 cycles after ncs rises; one cfg_update pulse; other registers stay 0x00.
- Writes 0x80F0, 0x810F, 0x82AA, 0x8355 back-to-back with 4 clk of ncs high between frames -> the four enable registers read 0xF0, 0x0F, 0xAA, 0x55; 4 cfg_update pulses; no frame_err.
- 15-bit frame, then a 17-bit frame with write bit set -> 2 frame_err pulses; all registers unchanged; no cfg_update.
- Frame 0x8512 (address 5) and frame 0x0433 (read) -> no register changes, no cfg_update, no frame_err.
- Assert rst after 8 bits of frame 0x84FF, release while ncs is still low, finish clocking the frame -> all registers 0x00 and no commit; the next full frame 0x8477 sets duty = 0x77.
- [SPI_READBACK_EN] Write 0x84C3, then read frame 0x0400 -> cipo_out shifts 1,1,0,0,0,0,1,1 on bits 8..15; with address 0x7F, cipo_out = 0 for all bits.
